// File: rtl/noc_arbiter_5to1.sv
// noc_arbiter_5to1
// Five-input, one-output wormhole packet arbiter for a router output port.
// Round-robin arbitration between Local/North/East/South/West inputs, with
// the grant held for a whole packet and a registered valid/ready output.
// out_sel uses the 000..100 port encoding consumed by the downstream demux.

module noc_arbiter_5to1 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4:0]                in_valid,
  input  logic [5*DATA_WIDTH-1:0]   in_data,
  input  logic [4:0]                in_last,
  output logic [4:0]                in_ready,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_last,
  output logic [2:0]                out_sel,
  input  logic                      out_ready
);

  localparam int NUM_PORTS = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // Adds two port numbers modulo 5; both operands are expected in 0..4.
  function automatic logic [2:0] port_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 4'd5) begin
      sum = sum - 4'd5;
    end
    return sum[2:0];
  endfunction

  // Architectural state
  state_t                  r_state;
  logic [2:0]              r_owner;
  logic [2:0]              r_ptr;
  logic                    r_out_valid;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic                    r_out_last;
  logic [2:0]              r_out_sel;

  // Arbitration and datapath nets
  logic [4:0]              w_rot_req;
  logic [2:0]              w_win_off;
  logic                    w_win_found;
  logic [2:0]              w_win_port;
  logic [2:0]              w_grant_port;
  logic                    w_grant_en;
  logic                    w_load;
  logic                    w_hs;
  logic                    w_grant_last;
  logic [DATA_WIDTH-1:0]   w_grant_data;
  logic [DATA_WIDTH-1:0]   w_port_data [NUM_PORTS];

  // Requests rotated so that bit 0 is the port currently holding priority.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_rot
    assign w_rot_req[gi]   = in_valid[port_add(r_ptr, 3'(gi))];
    assign w_port_data[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // Priority-encode the rotated request vector: lowest offset wins.
  always_comb begin
    w_win_off   = 3'd0;
    w_win_found = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (w_rot_req[k]) begin
        w_win_off   = k[2:0];
        w_win_found = 1'b1;
      end
    end
  end

  assign w_win_port = port_add(r_ptr, w_win_off);

  // While locked only the owner may be granted, even if it is idling.
  assign w_grant_port = (r_state == ST_LOCKED) ? r_owner : w_win_port;
  assign w_grant_en   = (r_state == ST_LOCKED) | w_win_found;

  // Output register is free when empty or being drained this cycle.
  assign w_load = !r_out_valid || out_ready;

  // One-hot ready toward the granted port; forced low during reset.
  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_ready
    assign in_ready[gi] = rst_n && w_load && w_grant_en && (w_grant_port == 3'(gi));
  end

  assign w_hs         = |(in_valid & in_ready);
  assign w_grant_last = in_last[w_grant_port];
  assign w_grant_data = w_port_data[w_grant_port];

  // Arbitration FSM and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= 3'd0;
      r_ptr       <= 3'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= 3'd0;
    end else begin
      if (w_hs) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_last  <= w_grant_last;
        r_out_sel   <= w_grant_port;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            if (w_grant_last) begin
              r_ptr <= port_add(w_grant_port, 3'd1);
            end else begin
              r_state <= ST_LOCKED;
              r_owner <= w_grant_port;
            end
          end
        end
        ST_LOCKED: begin
          if (w_hs && w_grant_last) begin
            r_state <= ST_IDLE;
            r_ptr   <= port_add(r_owner, 3'd1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_noc_arbiter_5to1.sv
// Testbench for noc_arbiter_5to1: randomized per-port packet sources, a
// behavioural arbitration model that predicts grants and pushes expected
// output flits into a queue, and an independent output monitor.

module tb_noc_arbiter_5to1;

  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [4:0]        in_valid;
  logic [5*DW-1:0]   in_data;
  logic [4:0]        in_last;
  logic [4:0]        in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic [2:0]        out_sel;
  logic              out_ready;

  always #5 clk = ~clk;

  noc_arbiter_5to1 #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic [2:0]    sel;
  } flit_t;

  flit_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Source-side stimulus state (held until accepted)
  logic [4:0]    drv_valid;
  logic [4:0]    drv_last;
  logic [DW-1:0] drv_data [5];

  // Reference model: packet owner (-1 = none), priority pointer, output full
  int m_owner;
  int m_ptr;
  bit m_ov;

  assign in_valid = drv_valid;
  assign in_last  = drv_last;
  for (genvar gi = 0; gi < 5; gi++) begin : g_pack
    assign in_data[gi*DW +: DW] = drv_data[gi];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic new_flit(input int i, input int pv, input int pl);
    drv_valid[i] = ($urandom_range(99) < pv);
    drv_data[i]  = $urandom;
    drv_last[i]  = ($urandom_range(99) < pl);
  endtask

  // One clock of stimulus: predict grant, check it, queue expected flit.
  task automatic cycle(input int pv, input int pl, input int pr);
    int         g;
    int         acc;
    bit         load;
    logic [4:0] exp_rdy;
    @(negedge clk);
    load = !m_ov || out_ready;
    g = -1;
    if (m_owner >= 0) g = m_owner;
    else begin
      for (int k = 0; k < 5; k++)
        if (g < 0 && drv_valid[(m_ptr + k) % 5]) g = (m_ptr + k) % 5;
    end
    exp_rdy = (g >= 0 && load) ? 5'(1 << g) : 5'b0;
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    acc = -1;
    if (g >= 0 && load && drv_valid[g]) begin
      acc = g;
      exp_q.push_back('{drv_data[g], drv_last[g], 3'(g)});
      if (drv_last[g]) begin
        m_owner = -1;
        m_ptr   = (g + 1) % 5;
      end else begin
        m_owner = g;
      end
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++)
      if (i == acc || !drv_valid[i]) new_flit(i, pv, pl);
    out_ready = ($urandom_range(99) < pr);
  endtask

  task automatic run(input int n, input int pv, input int pl, input int pr);
    for (int i = 0; i < 5; i++)
      if (!drv_valid[i]) new_flit(i, pv, pl);
    out_ready = ($urandom_range(99) < pr);
    for (int c = 0; c < n; c++) cycle(pv, pl, pr);
  endtask

  // Output monitor: pops expected flits on output handshakes, and checks
  // that a stalled output stays put.
  logic          mon_hold;
  logic [36:0]   mon_prev;
  initial mon_hold = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_hold = 1'b0;
    end else begin
      if (mon_hold)
        check("hold_stable", 64'({out_valid, out_last, out_sel, out_data}), 64'(mon_prev));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_data), 64'hDEAD);
        end else begin
          flit_t e;
          e = exp_q.pop_front();
          $display("out port=%0d data=%08h last=%0b", out_sel, out_data, out_last);
          check("out_data", 64'(out_data), 64'(e.data));
          check("out_last", 64'(out_last), 64'(e.last));
          check("out_sel", 64'(out_sel), 64'(e.sel));
        end
      end
      mon_hold = out_valid && !out_ready;
      mon_prev = {out_valid, out_last, out_sel, out_data};
    end
  end

  initial begin
    rst_n     = 1'b0;
    drv_valid = 5'b11111;
    drv_last  = 5'b00000;
    for (int i = 0; i < 5; i++) drv_data[i] = $urandom;
    out_ready = 1'b1;
    m_owner = -1;
    m_ptr   = 0;
    m_ov    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_sel", 64'(out_sel), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    drv_valid = 5'b00000;
    rst_n = 1'b1;

    // Fairness: every port always has single-flit packets, output never stalls
    run(30, 100, 100, 100);
    // Multi-flit packets, free-flowing output
    run(400, 60, 30, 100);
    // Heavy backpressure
    run(600, 80, 25, 50);
    // Sparse sources: owner bubbles mid-packet
    run(400, 40, 20, 80);
    // Long packets to land the reset inside one
    run(20, 100, 5, 100);

    // Reset mid-packet, then only port 2 requesting
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_sel", 64'(out_sel), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    exp_q.delete();
    m_owner = -1;
    m_ptr   = 0;
    m_ov    = 1'b0;
    drv_valid   = 5'b00100;
    drv_last[2] = 1'b1;
    out_ready   = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_grant_p2", 64'(in_ready), 64'b00100);
    run(1, 0, 100, 100);

    // Mixed random soak
    for (int p = 0; p < 6; p++)
      run(100, $urandom_range(20, 100), $urandom_range(10, 100), $urandom_range(30, 100));

    // Drain: stop new packets, free the output
    run(40, 0, 100, 100);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("drain_out_valid", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noc_arbiter_5to1.md
# noc_arbiter_5to1

Five-input, one-output packet arbiter for a router output port: the converging counterpart of the 5-way output demux. It merges flits from the Local, North, East, South and West input ports onto one output link with round-robin fairness. It locks the grant for a whole packet (wormhole) and drives a registered output with a valid/ready handshake. `out_sel` uses the same 3-bit port encoding (000..100) as the demux control, so the downstream demux can consume it directly.

## Interface
Parameters:
- `DATA_WIDTH`, 32, flit payload width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  5  per-port flit valid; bit i = port i (0 Local, 1 N, 2 E, 3 S, 4 W).
- `in_data`  in  5*DATA_WIDTH  port i flit at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_last`  in  5  port i flit is the packet tail.
- `in_ready`  out  5  port i flit accepted this cycle when `in_valid[i] && in_ready[i]`.
- `out_valid`  out  1  output flit valid (registered).
- `out_data`  out  DATA_WIDTH  output flit (registered).
- `out_last`  out  1  output flit is the tail (registered).
- `out_sel`  out  3  source port of the current output flit, 000..100 (registered).
- `out_ready`  in  1  downstream accepts the output flit.

## Operation
- State machine has two states. It resets to IDLE. Internal registers: `owner` (3 b) and `ptr` (3 b, 0..4).
- `load = !out_valid || out_ready`, meaning the output register can take a new flit this cycle.
- **IDLE:**
  - Winner w is the first i with `in_valid[i]=1`, scanning i = ptr, ptr+1, … mod 5.
  - `in_ready[w] = load`; all other `in_ready` bits are 0.
  - On handshake of a flit with `in_last=0`, go to LOCKED with `owner=w`.
  - On handshake of a flit with `in_last=1`, stay in IDLE and set `ptr=(w+1) mod 5`.
  - With no request, or with `load=0`, nothing changes.
- **LOCKED:**
  - `in_ready[owner] = load`; all other bits are 0.
  - Other ports are never granted, even if the owner deasserts `in_valid`. Bubbles are allowed.
  - On handshake with `in_last=1`, go to IDLE and set `ptr=(owner+1) mod 5`.
- **Output register:**
  - On any input handshake, load `out_data`, `out_last` and `out_sel` = source port, and set `out_valid=1`.
  - Else, if `out_ready=1`, clear `out_valid`. `out_data`, `out_last` and `out_sel` keep their last values.
  - While `out_valid && !out_ready`, all output registers are held stable.
- `in_ready` is combinational from state, `ptr`, `owner`, `in_valid`, `out_valid` and `out_ready`. It never depends on `in_data`.
- Input protocol: once a source asserts `in_valid`, it holds the valid and its data until accepted. The block does not check this.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_last=0`, `out_sel=3'b000`, state IDLE, `ptr=0`, `owner=0`. `in_ready=0` while `rst_n=0`.
- Latency: a flit accepted at edge N is visible on the outputs after edge N, which is 1 cycle.
- Throughput: 1 flit/cycle with `out_ready` held high, including back-to-back packets from different ports.
- Simultaneous events:
  - Output drain and new accept in the same cycle is allowed, because `load` includes `out_ready`.
  - The tail of one packet and the head of the next cannot be accepted in the same cycle, because only one port is granted per cycle. The next winner is arbitrated in the cycle after the tail, using the updated `ptr`.
- Single-flit packet (`in_last=1` on the head): the grant lasts 1 cycle and `ptr` advances.
- Wrap-around: a winner at port 4 sets `ptr=0`.
- Reset mid-packet: the lock is dropped and any in-flight output flit is discarded. No partial-packet recovery is attempted.

## Test plan
- **Reset:** assert `rst_n=0` mid-packet -> `out_valid=0`, `out_sel=000`, `in_ready=00000`. After release with port 2 valid, port 2 is granted first (ptr=0, ports 0/1 idle).
- **Fairness:** all 5 ports each send continuous single-flit packets, `out_ready=1` -> `out_sel` sequence 0,1,2,3,4,0,…, one flit per cycle, each `out_data` matching the granted port's flit.
- **Wormhole lock:** port 1 sends a 4-flit packet while ports 0 and 3 are valid -> 4 consecutive outputs with `out_sel=001`, `out_last` only on the 4th. Then port 3 is granted, then port 0.
- **Backpressure:** `out_ready=0` for 3 cycles with port 4 mid-packet -> outputs held stable, `in_ready=00000`. On `out_ready=1`, flow resumes with no loss or duplication.
- **Owner bubble:** port 0 drops `in_valid` for 2 cycles mid-packet while port 2 is valid -> `in_ready[2]` stays 0 and `out_valid` drops. Port 0's remaining flits follow before port 2 is granted.
- **Random soak:** random valid/last/ready -> per-port packets reach the output contiguous and in order, with no flit lost or duplicated (scoreboard).
